// File: rtl/xbar_alloc4x4.sv
// ---------------------------------------------------------------------------
// xbar_alloc4x4: packet-aware 4x4 crossbar output allocator, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module xbar_alloc4x4 #(
  parameter int unsigned PTR_RST = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_valid,
  input  logic [1:0] req_dst0,
  input  logic [1:0] req_dst1,
  input  logic [1:0] req_dst2,
  input  logic [1:0] req_dst3,
  input  logic [3:0] req_last,
  input  logic [3:0] out_ready,
  output logic [3:0] grant0,
  output logic [3:0] grant1,
  output logic [3:0] grant2,
  output logic [3:0] grant3,
  output logic [1:0] sel0,
  output logic [1:0] sel1,
  output logic [1:0] sel2,
  output logic [1:0] sel3,
  output logic [3:0] out_valid,
  output logic [3:0] pop,
  output logic [3:0] locked
);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  localparam logic [1:0] c_ptr_rst = 2'(PTR_RST);

  logic [1:0]  w_dst [4];
  logic [15:0] w_grant_all;
  logic [7:0]  w_sel_all;

  assign w_dst[0] = req_dst0;
  assign w_dst[1] = req_dst1;
  assign w_dst[2] = req_dst2;
  assign w_dst[3] = req_dst3;

  for (genvar j = 0; j < 4; j++) begin : g_out
    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [1:0] r_owner, w_owner_nxt;
    logic [3:0] w_req;
    logic       w_win_valid;
    logic [1:0] w_win;
    logic       w_active;
    logic       w_xfer;

    always_comb begin
      for (int i = 0; i < 4; i++) begin
        w_req[i] = req_valid[i] && (w_dst[i] == 2'(j));
      end
    end

    // Descending scan so the requester closest to the pointer is assigned last.
    always_comb begin
      w_win_valid = 1'b0;
      w_win       = 2'd0;
      if (r_state == ST_LOCKED) begin
        w_win_valid = w_req[r_owner];
        w_win       = r_owner;
      end else begin
        for (int k = 3; k >= 0; k--) begin
          if (w_req[r_ptr + 2'(k)]) begin
            w_win_valid = 1'b1;
            w_win       = r_ptr + 2'(k);
          end
        end
      end
    end

    assign w_active = w_win_valid && !rst;
    assign w_xfer   = w_active && out_ready[j];

    assign w_grant_all[j*4 +: 4] = w_active ? (4'b0001 << w_win) : 4'b0000;
    assign w_sel_all[j*2 +: 2]   = w_active ? w_win : 2'd0;
    assign out_valid[j]          = w_xfer;
    assign locked[j]             = (r_state == ST_LOCKED);

    always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      if (w_xfer) begin
        if (req_last[w_win]) begin
          w_state_nxt = ST_UNLOCKED;
          w_ptr_nxt   = w_win + 2'd1;
        end else begin
          w_state_nxt = ST_LOCKED;
          w_owner_nxt = w_win;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= ST_UNLOCKED;
        r_ptr   <= c_ptr_rst;
        r_owner <= 2'd0;
      end else begin
        r_state <= w_state_nxt;
        r_ptr   <= w_ptr_nxt;
        r_owner <= w_owner_nxt;
      end
    end
  end

  // A grant bit implies that input targets this output, so OR-ing is exact.
  always_comb begin
    pop = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        pop[i] = pop[i] | (out_valid[j] & w_grant_all[j*4 + i]);
      end
    end
  end

  assign grant0 = w_grant_all[3:0];
  assign grant1 = w_grant_all[7:4];
  assign grant2 = w_grant_all[11:8];
  assign grant3 = w_grant_all[15:12];
  assign sel0   = w_sel_all[1:0];
  assign sel1   = w_sel_all[3:2];
  assign sel2   = w_sel_all[5:4];
  assign sel3   = w_sel_all[7:6];

endmodule

`default_nettype wire

// File: tb/tb_xbar_alloc4x4.sv
// ---------------------------------------------------------------------------
// tb_xbar_alloc4x4: scoreboard bench for xbar_alloc4x4, rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_xbar_alloc4x4;

  localparam int PTR_RST = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid, req_last, out_ready;
  logic [1:0] req_dst0, req_dst1, req_dst2, req_dst3;
  logic [3:0] grant0, grant1, grant2, grant3;
  logic [1:0] sel0, sel1, sel2, sel3;
  logic [3:0] out_valid, pop, locked;

  typedef logic [35:0] vec_t;
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference: -1 owner means the output is free; prio is the first input scanned.
  int m_owner[4];
  int m_prio[4];

  xbar_alloc4x4 #(.PTR_RST(PTR_RST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_dst0(req_dst0), .req_dst1(req_dst1), .req_dst2(req_dst2), .req_dst3(req_dst3),
    .req_last(req_last), .out_ready(out_ready),
    .grant0(grant0), .grant1(grant1), .grant2(grant2), .grant3(grant3),
    .sel0(sel0), .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .out_valid(out_valid), .pop(pop), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic [3:0] v, input logic [7:0] d,
                       input logic [3:0] l, input logic [3:0] rdy);
    logic [3:0] g [4];
    logic [1:0] s [4];
    logic [3:0] ov, pp, lk;
    int win, o, cand;
    @(posedge clk);
    #1;
    rst = r; req_valid = v; req_last = l; out_ready = rdy;
    req_dst0 = d[1:0]; req_dst1 = d[3:2]; req_dst2 = d[5:4]; req_dst3 = d[7:6];
    ov = 4'b0; pp = 4'b0; lk = 4'b0;
    for (int j = 0; j < 4; j++) begin
      lk[j] = (m_owner[j] >= 0);
      g[j] = 4'b0; s[j] = 2'b0; win = -1;
      if (!r) begin
        o = m_owner[j];
        if (o >= 0) begin
          if (v[o] && d[o*2 +: 2] == j) win = o;
        end else begin
          for (int k = 0; k < 4; k++) begin
            cand = (m_prio[j] + k) % 4;
            if (win < 0 && v[cand] && d[cand*2 +: 2] == j) win = cand;
          end
        end
      end
      if (win >= 0) begin
        g[j] = 4'b0001 << win;
        s[j] = win[1:0];
        if (rdy[j]) begin
          ov[j] = 1'b1;
          pp[win] = 1'b1;
          if (l[win]) begin
            m_owner[j] = -1;
            m_prio[j]  = (win + 1) % 4;
          end else begin
            m_owner[j] = win;
          end
        end
      end
    end
    if (r) begin
      for (int j = 0; j < 4; j++) begin
        m_owner[j] = -1;
        m_prio[j]  = PTR_RST;
      end
    end
    exp_q.push_back({g[3], g[2], g[1], g[0], s[3], s[2], s[1], s[0], ov, pp, lk});
  endtask

  initial begin : monitor
    vec_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {grant3, grant2, grant1, grant0, sel3, sel2, sel1, sel0, out_valid, pop, locked};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL outputs @%0t: actual g=%h s=%h ov=%h pop=%h lk=%h required g=%h s=%h ov=%h pop=%h lk=%h",
                   $time, a[35:20], a[19:12], a[11:8], a[7:4], a[3:0],
                   e[35:20], e[19:12], e[11:8], e[7:4], e[3:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; req_valid = 4'b0; req_last = 4'b0; out_ready = 4'b0;
    req_dst0 = 2'd0; req_dst1 = 2'd0; req_dst2 = 2'd0; req_dst3 = 2'd0;
    for (int j = 0; j < 4; j++) begin
      m_owner[j] = -1;
      m_prio[j]  = PTR_RST;
    end
    repeat (2) @(posedge clk);

    // Reset state, then identity mapping
    drive(1'b1, 4'hF, 8'he4, 4'hF, 4'hF);
    drive(1'b0, 4'hF, 8'he4, 4'hF, 4'hF);
    // Rotation on output 3, including wrap
    repeat (5) drive(1'b0, 4'hF, 8'hFF, 4'hF, 4'hF);

    // Packet lock: input 1 sends 3 beats to output 0, input 0 competing
    drive(1'b1, 4'h0, 8'h00, 4'h0, 4'h0);
    drive(1'b0, 4'h3, 8'h00, 4'h1, 4'hF);
    drive(1'b0, 4'h3, 8'h00, 4'h1, 4'hF);
    drive(1'b0, 4'h3, 8'h00, 4'h3, 4'hF);
    drive(1'b0, 4'h3, 8'h00, 4'h1, 4'hF);

    // Bubble and backpressure mid-packet
    drive(1'b1, 4'h0, 8'h00, 4'h0, 4'h0);
    drive(1'b0, 4'h3, 8'h00, 4'h1, 4'hF);
    drive(1'b0, 4'h1, 8'h00, 4'h1, 4'hF);
    drive(1'b0, 4'h3, 8'h00, 4'h1, 4'hE);
    drive(1'b0, 4'h3, 8'h00, 4'h3, 4'hF);
    drive(1'b0, 4'h3, 8'h00, 4'h3, 4'hF);

    // Reset in the middle of a locked packet
    drive(1'b0, 4'h3, 8'h00, 4'h1, 4'hF);
    drive(1'b0, 4'h3, 8'h00, 4'h1, 4'hF);
    drive(1'b1, 4'h3, 8'h00, 4'h1, 4'hF);
    drive(1'b0, 4'h3, 8'h00, 4'h1, 4'hF);
    drive(1'b0, 4'h3, 8'h00, 4'h3, 4'hF);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 63) == 0),
            4'($urandom),
            8'($urandom),
            4'($urandom) | 4'($urandom),
            4'($urandom) | 4'($urandom));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: actual %0d pending entries required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
